mem_access_unit: RTL



---
 rtl/mem_access_pkg.sv | 63 ++++++
 rtl/mem_lane_align.sv | 18 +
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings and byte-lane helpers for the memory access unit.
// Lanes are little-endian: byte lane = addr[1:0], half lane = addr[1].
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW_RD,
        ST_WR,
        ST_RESP
    } state_t;

    function automatic logic is_sub_word(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

    // Size 3 is handled as a word, so it traps on the same offsets as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            default: bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  lo,
                                                 input logic [1:0]  size,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  lo,
                                               input logic [1:0]  size);
        logic [31:0] r;
        r = old_word;
        case (size)
            SZ_BYTE: r[{lo, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: r[{lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extract/extend for loads, lane merge for
// read-modify-write stores.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [31:0] st_wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] ld_data,
    output logic [31:0] merged_data
);

    assign ld_data     = lane_extract(mem_rdata, addr_lo, size, sgn);
    assign merged_data = lane_merge(mem_rdata, st_wdata, addr_lo, size);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a word-only data memory.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
`ifdef MISALIGN_TRAP_EN
    output logic              resp_err,
`endif
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] merged_q, merged_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] merged_data;
    logic              trap;

`ifdef MISALIGN_TRAP_EN
    logic err_q, err_d;

    assign trap     = is_misaligned(req_size, req_addr[1:0]);
    assign resp_err = err_q;
`else
    assign trap = 1'b0;
`endif

    mem_lane_align u_align (
        .mem_rdata   (mem_rdata),
        .st_wdata    (wdata_q),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .sgn         (signed_q),
        .ld_data     (ld_data),
        .merged_data (merged_data)
    );

    assign mem_add    = {addr_q[ADDR_W-1:2], 2'b00};
    assign resp_rdata = we_q ? '0 : rdata_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        signed_d   = signed_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        merged_d   = merged_q;
        rdata_d    = rdata_q;
`ifdef MISALIGN_TRAP_EN
        err_d      = err_q;
`endif
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d   = req_addr;
                    size_d   = (req_size == 2'd3) ? SZ_WORD : req_size;
                    signed_d = req_signed;
                    we_d     = req_we;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
`ifdef MISALIGN_TRAP_EN
                    err_d    = trap;
`endif
                    if (trap) begin
                        state_d = ST_RESP;
                    end else if (!req_we) begin
                        state_d = ST_RD;
                    end else if (is_sub_word(req_size)) begin
                        state_d = ST_RMW_RD;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_RD: begin
                mem_read = 1'b1;
                rdata_d  = ld_data;
                state_d  = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_read = 1'b1;
                merged_d = merged_data;
                state_d  = ST_WR;
            end
            ST_WR: begin
                mem_write = 1'b1;
                mem_wdata = is_sub_word(size_q) ? merged_q : wdata_q;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
`ifdef MISALIGN_TRAP_EN
            err_q    <= err_d;
`endif
        end
    end

endmodule
